// File: rtl/kv_cache_controller.sv
// Purpose : small fully-associative key/value store with GET/PUT/DEL, linear scan over register entries.
// Latency : result (ready_out) 3+i cycles after request for a decisive hit at entry i, NUM_ENTRIES+2 on a miss.
// Backpres: none; one request in flight, later requests wait until the held opcode drops back to NOOP.
//
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   operation_in/key_in/value_in - request; sampled only while idle
//   ready_out                  - one-cycle result strobe
//   op_succ_out, value_out     - result of the last executed request, held until the next one
//   count_out                  - number of valid entries

package ctrl_types_pkg;
    typedef enum logic [1:0] {
        NOOP = 2'b00,
        GET  = 2'b01,
        PUT  = 2'b10,
        DEL  = 2'b11
    } operation_e;
endpackage

module kv_cache_controller #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 64,
    parameter int NUM_ENTRIES = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  ctrl_types_pkg::operation_e         operation_in,
    input  logic [KEY_WIDTH-1:0]               key_in,
    input  logic [VALUE_WIDTH-1:0]             value_in,
    output logic                               ready_out,
    output logic                               op_succ_out,
    output logic [VALUE_WIDTH-1:0]             value_out,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_out
);
    import ctrl_types_pkg::*;

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES-1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EXEC, S_DONE, S_RELEASE} state_e;

    typedef struct packed {
        logic                   valid;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

    state_e                 state_q, state_d;
    entry_t                 entry_q [NUM_ENTRIES];
    operation_e             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   hit_q;
    logic                   free_vld_q;
    logic [IDX_W-1:0]       free_idx_q;
    logic [CNT_W-1:0]       count_q;

    logic scan_hit;
    logic scan_last;

    assign scan_hit  = entry_q[idx_q].valid && (entry_q[idx_q].key == key_q);
    assign scan_last = (idx_q == LAST_IDX);

    assign ready_out = (state_q == S_DONE);
    assign count_out = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (operation_in != NOOP) state_d = S_SCAN;
            S_SCAN:    if (scan_hit || scan_last) state_d = S_EXEC;
            S_EXEC:    state_d = S_DONE;
            S_DONE:    state_d = S_RELEASE;
            // Upstream may still be holding the request it just got an answer for.
            S_RELEASE: if (operation_in == NOOP) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
            op_q        <= NOOP;
            key_q       <= '0;
            val_q       <= '0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            count_q     <= '0;
            op_succ_out <= 1'b0;
            value_out   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (operation_in != NOOP) begin
                        op_q       <= operation_in;
                        key_q      <= key_in;
                        val_q      <= value_in;
                        idx_q      <= '0;
                        hit_q      <= 1'b0;
                        free_vld_q <= 1'b0;
                        free_idx_q <= '0;
                    end
                end
                S_SCAN: begin
                    if (!entry_q[idx_q].valid && !free_vld_q) begin
                        free_vld_q <= 1'b1;
                        free_idx_q <= idx_q;
                    end
                    // On a hit idx_q is frozen so EXEC addresses the matching entry.
                    if (scan_hit)        hit_q <= 1'b1;
                    else if (!scan_last) idx_q <= idx_q + IDX_W'(1);
                end
                S_EXEC: begin
                    op_succ_out <= 1'b0;
                    value_out   <= '0;
                    case (op_q)
                        GET: begin
                            if (hit_q) begin
                                op_succ_out <= 1'b1;
                                value_out   <= entry_q[idx_q].value;
                            end
                        end
                        PUT: begin
                            if (hit_q) begin
                                entry_q[idx_q].value <= val_q;
                                op_succ_out          <= 1'b1;
                                value_out            <= val_q;
                            end else if (free_vld_q) begin
                                entry_q[free_idx_q].valid <= 1'b1;
                                entry_q[free_idx_q].key   <= key_q;
                                entry_q[free_idx_q].value <= val_q;
                                count_q                   <= count_q + CNT_W'(1);
                                op_succ_out               <= 1'b1;
                                value_out                 <= val_q;
                            end
                        end
                        DEL: begin
                            if (hit_q) begin
                                entry_q[idx_q].valid <= 1'b0;
                                count_q              <= count_q - CNT_W'(1);
                                op_succ_out          <= 1'b1;
                                value_out            <= entry_q[idx_q].value;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/kv_cache_controller.md
KV_CACHE_CONTROLLER -- requirements
Module: kv_cache_controller

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32: key width in bits.
REQ-002 SHALL have parameter VALUE_WIDTH, default 64: value width in bits.
REQ-003 SHALL have parameter NUM_ENTRIES, default 8: number of storage entries; legal range is 2 or more.
REQ-004 SHALL have a port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have a port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have a port operation_in  input  ctrl_types_pkg::operation_e (2 bits): request opcode; NOOP=00, GET=01, PUT=10, DEL=11.
REQ-007 SHALL have a port key_in  input  KEY_WIDTH: request key.
REQ-008 SHALL have a port value_in  input  VALUE_WIDTH: request value; used only by PUT.
REQ-009 SHALL have a port ready_out  output  1: one-cycle pulse marking the result as valid.
REQ-010 SHALL have a port op_succ_out  output  1: operation success flag.
REQ-011 SHALL have a port value_out  output  VALUE_WIDTH: result value.
REQ-012 SHALL have a port count_out  output  $clog2(NUM_ENTRIES+1): number of valid entries.

Function
REQ-013 SHALL store NUM_ENTRIES entries in registers; each entry holds {valid, key, value}.
REQ-014 SHALL implement FSM states IDLE, SCAN, EXEC, DONE and RELEASE.
REQ-015 IDLE: when operation_in != NOOP in cycle t, the block SHALL latch op, key and value, clear scan index to 0 and enter SCAN at t+1. With NOOP it stays in IDLE.
REQ-016 SHALL ignore operation_in, key_in and value_in in every state except IDLE; the latched copies are authoritative.
REQ-017 SCAN: SHALL examine entry[idx] in cycle t+1+idx.
  - A hit is valid & key == latched key.
  - The lowest-indexed invalid entry SHALL be recorded as the free slot.
REQ-018 SCAN SHALL move to EXEC after the first hit, or after examining idx = NUM_ENTRIES-1 without a hit.
REQ-019 EXEC (one cycle) SHALL update storage, op_succ_out and value_out:
  - GET hit: succ=1, value = stored value.
  - GET miss: succ=0, value = 0.
  - PUT hit: overwrite the value; succ=1, value = new value.
  - PUT miss with a free slot: write {1, key, value} to the lowest free index; succ=1, value = new value.
  - PUT miss when full: no write; succ=0, value = 0.
  - DEL hit: clear valid; succ=1, value = deleted value.
  - DEL miss: succ=0, value = 0.
REQ-020 DONE SHALL assert ready_out for exactly one cycle, then move to RELEASE. For a decisive entry at idx i, ready_out is high in cycle t+3+i.
REQ-021 RELEASE SHALL stay until operation_in == NOOP, then enter IDLE next cycle. This prevents re-execution of a request that upstream still holds.
REQ-022 op_succ_out and value_out SHALL hold their values from EXEC until the next EXEC.
REQ-023 count_out SHALL change in the cycle after EXEC:
  - increment on a PUT insertion into a free slot;
  - decrement on a DEL hit;
  - otherwise unchanged.
  - It never exceeds NUM_ENTRIES and never underflows.
REQ-024 Keys SHALL be unique: PUT to an existing key overwrites and never allocates.
REQ-025 Key value 0 SHALL be an ordinary key; validity is carried only by the valid bit.
REQ-026 The block SHALL never assert ready_out outside DONE.

Reset
REQ-027 Asserting rst SHALL immediately force:
  - state to IDLE;
  - all valid bits, stored keys and stored values to 0;
  - ready_out=0, op_succ_out=0, value_out=0, count_out=0;
  - scan index and latched request to 0.
REQ-028 Reset asserted mid-SCAN or mid-EXEC SHALL abort the operation with no storage write surviving and no ready_out pulse.
REQ-029 After rst deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-030 Bench with NUM_ENTRIES=4. After reset:
  - Stimulus: GET key=0x10.
  - Required: ready_out high at t+6, succ=0, value=0, count=0.
REQ-031 PUT then GET:
  - Stimulus: PUT key=0x10, value=0xDEAD_BEEF, with the store empty; then GET key=0x10.
  - Required for PUT: ready_out at t+6, succ=1, count=1.
  - Required for GET: hit at idx 0, ready_out at t+3, value=0xDEAD_BEEF, succ=1.
REQ-032 Overwrite:
  - Stimulus: PUT key=0x10, value=0x1; then PUT key=0x10, value=0x2; then GET key=0x10.
  - Required: value=0x2, count=1.
REQ-033 Full store:
  - Stimulus: PUT keys 1..4; then PUT key=5.
  - Required: key=5 gets succ=0 with no write, count=4.
  - Then DEL key=2 (succ=1, count=3) and PUT key=5; key=5 is stored at idx 1.
REQ-034 Held request:
  - Stimulus: operation_in held at GET for 10 cycles after ready_out.
  - Required: exactly one ready_out pulse; IDLE is re-entered only after NOOP.
REQ-035 Reset mid-operation:
  - Stimulus: assert rst during SCAN of PUT key=7.
  - Required: no ready_out; all outputs 0; after release, GET key=7 returns succ=0.
